// File: rtl/instr_sequencer.sv
// Instruction fetch/issue engine: reads 8-bit instructions from a synchronous ROM,
// issues opcode/rd/rs one at a time and stalls on product/div until alu_done or timeout.
module instr_sequencer #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned MD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_data,
  output logic [2:0]        opcode,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic              issue_valid,
  input  logic              alu_done,
  output logic              busy,
  output logic              halted,
  output logic              md_timeout,
  output logic [7:0]        instr_count
);

  localparam int unsigned CNT_W    = $clog2(MD_TIMEOUT + 1);
  localparam int unsigned ICOUNT_W = 8;

  localparam logic [2:0] OP_PRODUCT = 3'b101;
  localparam logic [2:0] OP_DIV     = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [2:0]           opcode_q, opcode_d;
  logic [1:0]           rd_q, rd_d;
  logic [1:0]           rs_q, rs_d;
  logic                 last_q, last_d;
  logic                 issue_valid_q, issue_valid_d;
  logic                 busy_q, busy_d;
  logic                 halted_q, halted_d;
  logic                 md_timeout_q, md_timeout_d;
  logic [ICOUNT_W-1:0]  instr_count_q, instr_count_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;

  logic                 is_multi;
  logic                 wait_expired;
  logic                 wait_exit;
  logic                 start_ok;

  assign is_multi     = (opcode_q == OP_PRODUCT) || (opcode_q == OP_DIV);
  // Expires on the MD_TIMEOUT-th WAIT cycle; the counter holds cycles already spent.
  assign wait_expired = (wait_cnt_q == CNT_W'(MD_TIMEOUT - 1));
  assign wait_exit    = alu_done || wait_expired;
  assign start_ok     = start && ((state_q == S_IDLE) || (state_q == S_HALT));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: state_d = S_ISSUE;
      S_ISSUE: begin
        if (is_multi)    state_d = S_WAIT;
        else if (last_q) state_d = S_HALT;
        else             state_d = S_FETCH;
      end
      S_WAIT:  if (wait_exit) state_d = last_q ? S_HALT : S_FETCH;
      S_HALT:  if (start) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    pc_d          = pc_q;
    opcode_d      = opcode_q;
    rd_d          = rd_q;
    rs_d          = rs_q;
    last_d        = last_q;
    md_timeout_d  = md_timeout_q;
    instr_count_d = instr_count_q;
    wait_cnt_d    = wait_cnt_q;

    if (start_ok) begin
      pc_d          = ADDR_W'(START_ADDR);
      instr_count_d = '0;
      md_timeout_d  = 1'b0;
    end

    if (state_q == S_LATCH) begin
      opcode_d = imem_data[7:5];
      rd_d     = imem_data[4:3];
      rs_d     = imem_data[2:1];
      last_d   = imem_data[0];
    end

    if (state_q == S_ISSUE) begin
      pc_d       = pc_q + ADDR_W'(1);
      wait_cnt_d = '0;
      if (instr_count_q != {ICOUNT_W{1'b1}}) begin
        instr_count_d = instr_count_q + ICOUNT_W'(1);
      end
    end

    if (state_q == S_WAIT) begin
      // A completion in the expiring cycle takes priority over the timeout flag.
      if (wait_exit) begin
        wait_cnt_d = '0;
        if (!alu_done) md_timeout_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end

    issue_valid_d = (state_d == S_ISSUE);
    halted_d      = (state_d == S_HALT);
    busy_d        = (state_d == S_FETCH) || (state_d == S_LATCH) ||
                    (state_d == S_ISSUE) || (state_d == S_WAIT);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= ADDR_W'(START_ADDR);
      opcode_q      <= 3'b000;
      rd_q          <= 2'b00;
      rs_q          <= 2'b00;
      last_q        <= 1'b0;
      issue_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      md_timeout_q  <= 1'b0;
      instr_count_q <= '0;
      wait_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      opcode_q      <= opcode_d;
      rd_q          <= rd_d;
      rs_q          <= rs_d;
      last_q        <= last_d;
      issue_valid_q <= issue_valid_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
      md_timeout_q  <= md_timeout_d;
      instr_count_q <= instr_count_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign opcode      = opcode_q;
  assign rd          = rd_q;
  assign rs          = rs_q;
  assign issue_valid = issue_valid_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign md_timeout  = md_timeout_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: cycle-by-cycle vector tables plus
// hand-written sequences for timeout, PC wrap/saturation and mid-run reset.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, alu_done;
  logic [7:0] imem_addr, imem_data;
  logic [2:0] opcode;
  logic [1:0] rd, rs;
  logic       issue_valid, busy, halted, md_timeout;
  logic [7:0] instr_count;

  logic [7:0] rom [256];

  int tests = 0;
  int fails = 0;

  instr_sequencer #(.ADDR_W(8), .START_ADDR(0), .MD_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
    .opcode(opcode), .rd(rd), .rs(rs), .issue_valid(issue_valid), .alu_done(alu_done),
    .busy(busy), .halted(halted), .md_timeout(md_timeout), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM: data one cycle after address
  always @(posedge clk) imem_data <= rom[imem_addr];

  typedef struct {
    string       name;
    logic        rst;
    logic        start;
    logic        done;
    logic [26:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string n, logic r, logic s, logic d,
                              logic iv, logic [2:0] op, logic [1:0] rde, logic [1:0] rse,
                              logic b, logic h, logic t, logic [7:0] c, logic [7:0] a);
    vec_t v;
    v.name  = n;
    v.rst   = r;
    v.start = s;
    v.done  = d;
    v.exp   = {iv, op, rde, rse, b, h, t, c, a};
    return v;
  endfunction

  function automatic logic [26:0] obs();
    return {issue_valid, opcode, rd, rs, busy, halted, md_timeout, instr_count, imem_addr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs held for one cycle, outputs sampled 1ns after the closing edge
  task automatic step(input logic r, input logic s, input logic d);
    rst = r; start = s; alu_done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].start, vq[i].done);
      chk(vq[i].name, 32'(obs()), 32'(vq[i].exp));
    end
    vq.delete();
  endtask

  task automatic fill_rom(input logic [7:0] w);
    for (int i = 0; i < 256; i++) rom[i] = w;
  endtask

  initial begin
    int ivs;
    rst = 1'b1; start = 1'b0; alu_done = 1'b0;
    fill_rom(8'h00);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("reset_state", 32'(obs()), 32'd0);

    // Three single-cycle ops, LAST on the third; then restart from HALT
    rom[0] = 8'b0000_0000; rom[1] = 8'b0010_1000; rom[2] = 8'b0100_0001;
    vq.push_back(mk("t1_c1_fetch0",   0,1,0, 0,3'd0,2'd0,2'd0, 1,0,0, 8'd0, 8'd0));
    vq.push_back(mk("t1_c2_latch0",   0,0,0, 0,3'd0,2'd0,2'd0, 1,0,0, 8'd0, 8'd0));
    vq.push_back(mk("t1_c3_issue0",   0,0,0, 1,3'd0,2'd0,2'd0, 1,0,0, 8'd0, 8'd0));
    vq.push_back(mk("t1_c4_fetch1",   0,0,0, 0,3'd0,2'd0,2'd0, 1,0,0, 8'd1, 8'd1));
    vq.push_back(mk("t1_c5_latch1",   0,0,0, 0,3'd0,2'd0,2'd0, 1,0,0, 8'd1, 8'd1));
    vq.push_back(mk("t1_c6_issue1",   0,0,0, 1,3'd1,2'd1,2'd0, 1,0,0, 8'd1, 8'd1));
    vq.push_back(mk("t1_c7_fetch2",   0,0,0, 0,3'd1,2'd1,2'd0, 1,0,0, 8'd2, 8'd2));
    vq.push_back(mk("t1_c8_latch2",   0,0,0, 0,3'd1,2'd1,2'd0, 1,0,0, 8'd2, 8'd2));
    vq.push_back(mk("t1_c9_issue2",   0,0,0, 1,3'd2,2'd0,2'd0, 1,0,0, 8'd2, 8'd2));
    vq.push_back(mk("t1_c10_halt",    0,0,0, 0,3'd2,2'd0,2'd0, 0,1,0, 8'd3, 8'd3));
    vq.push_back(mk("t1_c11_hold",    0,0,1, 0,3'd2,2'd0,2'd0, 0,1,0, 8'd3, 8'd3));
    vq.push_back(mk("t6_restart",     0,1,0, 0,3'd2,2'd0,2'd0, 1,0,0, 8'd0, 8'd0));
    vq.push_back(mk("t6_busy_start",  0,1,0, 0,3'd2,2'd0,2'd0, 1,0,0, 8'd0, 8'd0));
    vq.push_back(mk("t6_reissue0",    0,0,0, 1,3'd0,2'd0,2'd0, 1,0,0, 8'd0, 8'd0));
    run_table();

    // Product with alu_done on the 4th WAIT cycle; stray alu_done/start ignored
    rom[0] = 8'b1010_0000; rom[1] = 8'b0000_0001;
    vq.push_back(mk("t2_reset",       1,0,0, 0,3'd0,2'd0,2'd0, 0,0,0, 8'd0, 8'd0));
    vq.push_back(mk("t2_c1_fetch",    0,1,0, 0,3'd0,2'd0,2'd0, 1,0,0, 8'd0, 8'd0));
    vq.push_back(mk("t2_c2_latch",    0,0,0, 0,3'd0,2'd0,2'd0, 1,0,0, 8'd0, 8'd0));
    vq.push_back(mk("t2_c3_issue",    0,0,0, 1,3'd5,2'd0,2'd0, 1,0,0, 8'd0, 8'd0));
    vq.push_back(mk("t2_c4_wait1",    0,0,1, 0,3'd5,2'd0,2'd0, 1,0,0, 8'd1, 8'd1));
    vq.push_back(mk("t2_c5_wait2",    0,0,0, 0,3'd5,2'd0,2'd0, 1,0,0, 8'd1, 8'd1));
    vq.push_back(mk("t2_c6_wait3",    0,0,0, 0,3'd5,2'd0,2'd0, 1,0,0, 8'd1, 8'd1));
    vq.push_back(mk("t2_c7_wait4",    0,0,0, 0,3'd5,2'd0,2'd0, 1,0,0, 8'd1, 8'd1));
    vq.push_back(mk("t2_c8_fetch",    0,0,1, 0,3'd5,2'd0,2'd0, 1,0,0, 8'd1, 8'd1));
    vq.push_back(mk("t2_c9_latch",    0,1,1, 0,3'd5,2'd0,2'd0, 1,0,0, 8'd1, 8'd1));
    vq.push_back(mk("t2_c10_issue",   0,0,0, 1,3'd0,2'd0,2'd0, 1,0,0, 8'd1, 8'd1));
    vq.push_back(mk("t2_c11_halt",    0,0,0, 0,3'd0,2'd0,2'd0, 0,1,0, 8'd2, 8'd2));
    run_table();

    // Div with LAST and no alu_done: 16 WAIT cycles then timeout
    rom[0] = 8'b1100_0001;
    step(1, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 18; i++) step(0, 0, 0);
    chk("t3_wait16_busy", 32'({busy, halted, md_timeout}), 32'b100);
    step(0, 0, 0);
    chk("t3_timeout_halt", 32'({busy, halted, md_timeout}), 32'b011);
    chk("t3_count", 32'(instr_count), 32'd1);
    step(0, 1, 0);
    chk("t3_restart_clears", 32'({busy, halted, md_timeout, instr_count}), 32'({3'b100, 8'd0}));
    for (int i = 0; i < 18; i++) step(0, 0, 0);
    chk("t3_wait16_again", 32'({busy, halted, md_timeout}), 32'b100);
    step(0, 0, 1);
    chk("t3_done_beats_timeout", 32'({busy, halted, md_timeout}), 32'b010);

    // 257 compares, no LAST: PC wraps, count saturates
    fill_rom(8'b1110_0000);
    step(1, 0, 0);
    step(0, 1, 0);
    ivs = 0;
    for (int c = 1; c <= 772; c++) begin
      if (issue_valid) ivs++;
      if (c == 765) chk("t4_count254", 32'(instr_count), 32'd254);
      if (c == 766) chk("t4_addr255", 32'(imem_addr), 32'd255);
      if (c == 766) chk("t4_count255", 32'(instr_count), 32'd255);
      if (c == 769) chk("t4_addr_wrap", 32'(imem_addr), 32'd0);
      if (c == 772) chk("t4_count_sat", 32'(instr_count), 32'd255);
      if (c == 772) chk("t4_issues", 32'(ivs), 32'd257);
      if (c < 772) step(0, 0, 0);
    end

    // Reset during WAIT and during LATCH
    fill_rom(8'h00);
    rom[0] = 8'b1010_0000;
    step(1, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("t5_in_wait", 32'({busy, opcode, instr_count}), 32'({1'b1, 3'd5, 8'd1}));
    step(1, 0, 0);
    chk("t5_rst_wait", 32'(obs()), 32'd0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("t5_rst_latch", 32'(obs()), 32'd0);
    step(0, 0, 0);
    chk("t5_idle_stays", 32'(obs()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
